axi_rd_line_responder: RTL and testbench



---
 rtl/axi_rd_resp_pkg.sv | 76 +++++++
 rtl/axi_rd_line_responder_fifo.sv | 69 ++++++
 rtl/axi_rd_line_responder.sv | 198 +++++++++++++++++++
 tb/tb_axi_rd_line_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_resp_pkg.sv
// Shared types and constants for the AXI read line responder.
// Holds the FSM state encoding, AXI response codes, burst encodings and the
// request/response structs used as the default AXI port types.
package axi_rd_resp_pkg;

    localparam int unsigned IdWidth             = 4;
    localparam int unsigned UserWidth           = 1;
    localparam int unsigned MemAddrWidthDefault = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef logic [MemAddrWidthDefault-1:0] mem_word_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        BURST,
        ERR,
        WDRAIN,
        WRESP
    } state_e;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        addr;
        logic [7:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
    } axi_ax_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [63:0]          data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_resp_t;

endpackage

// File: rtl/axi_rd_line_responder_fifo.sv
// Small synchronous return FIFO (no fall-through) holding memory read data
// until the R channel accepts it. Push while full and pop while empty are
// ignored; the responder's credit logic keeps either from happening.
module axi_rd_line_responder_fifo #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 2,
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [PtrWidth:0]    usage_o
);

    localparam logic [PtrWidth-1:0] LastPtr   = PtrWidth'(Depth - 1);
    localparam logic [PtrWidth:0]   FullCount = (PtrWidth + 1)'(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth:0]    count_q;
    logic                 push_ok;
    logic                 pop_ok;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrWidth'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FullCount);
    assign usage_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointers and fill level; reset empties the buffer instantly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + (PtrWidth + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - (PtrWidth + 1)'(1);
            end
        end
    end

    // Data storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axi_rd_line_responder.sv
// AXI4 read-only subordinate that serves cache-line refill bursts from a
// synchronous single-port 64-bit word memory. One AR at a time; one memory
// read per beat; a 2-entry return FIFO with credit-based issue keeps R at
// full throughput under r_ready back-pressure. Illegal bursts (too long,
// size other than 8 bytes, WRAP) are answered with SLVERR beats and no
// memory traffic.
// Optional: define AXI_RD_RESP_WRITE_ERR_EN to drain writes and answer them
// with a SLVERR B response; without it the write channels are tied off.
module axi_rd_line_responder
    import axi_rd_resp_pkg::*;
#(
    parameter int unsigned AxiIdWidth   = IdWidth,
    parameter int unsigned AxiUserWidth = UserWidth,
    parameter int unsigned MemAddrWidth = MemAddrWidthDefault,
    parameter int unsigned MaxBurstLen  = 8,
    parameter type         mst_req_t    = axi_req_t,
    parameter type         mst_resp_t   = axi_resp_t
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  mst_req_t                axi_req_i,
    output mst_resp_t               axi_resp_o,
    output logic                    mem_req_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    input  logic [63:0]             mem_rdata_i
);

    state_e                  state_q;
    state_e                  state_d;
    logic [AxiIdWidth-1:0]   id_q;
    logic [7:0]              len_q;
    logic [1:0]              burst_q;
    logic [MemAddrWidth-1:0] addr_q;
    logic [8:0]              issue_cnt_q;
    logic [7:0]              beat_cnt_q;
    logic                    inflight_q;

    logic                    fifo_empty;
    logic                    fifo_full_unused;
    logic [1:0]              fifo_usage;
    logic [63:0]             fifo_data;

    logic                    ar_hs;
    logic                    ar_bad;
    logic                    r_valid;
    logic                    r_hs;
    logic                    fifo_pop;
    logic                    beat_last;
    logic                    issue;
    logic [2:0]              occupancy;
    logic                    unused_req;

`ifdef AXI_RD_RESP_WRITE_ERR_EN
    logic                    aw_hs;
    assign aw_hs = (state_q == IDLE) && !axi_req_i.ar_valid && axi_req_i.aw_valid;
`endif

    assign unused_req = ^axi_req_i;

    assign ar_hs     = (state_q == IDLE) && axi_req_i.ar_valid;
    assign ar_bad    = ({1'b0, axi_req_i.ar.len} >= 9'(MaxBurstLen))
                    || (axi_req_i.ar.size != 3'd3)
                    || (axi_req_i.ar.burst == BURST_WRAP);
    assign beat_last = (beat_cnt_q == len_q);
    assign r_valid   = ((state_q == BURST) && !fifo_empty) || (state_q == ERR);
    assign r_hs      = r_valid && axi_req_i.r_ready;
    assign fifo_pop  = (state_q == BURST) && r_hs;

    // A beat leaving the FIFO this cycle frees its slot for a new request.
    assign occupancy = {1'b0, fifo_usage} + {2'b00, inflight_q} - {2'b00, fifo_pop};
    assign issue     = (state_q == BURST)
                    && (issue_cnt_q <= {1'b0, len_q})
                    && (occupancy < 3'd2);

    assign mem_req_o  = issue;
    assign mem_addr_o = addr_q;

    axi_rd_line_responder_fifo #(
        .DataWidth (64),
        .Depth     (2)
    ) i_return_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (inflight_q),
        .data_i  (mem_rdata_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full_unused),
        .usage_o (fifo_usage)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst attributes latched on AR, then issue/beat counters and address stepping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q        <= '0;
            len_q       <= '0;
            burst_q     <= '0;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (ar_hs) begin
                id_q        <= axi_req_i.ar.id;
                len_q       <= axi_req_i.ar.len;
                burst_q     <= axi_req_i.ar.burst;
                addr_q      <= axi_req_i.ar.addr[MemAddrWidth+2:3];
                issue_cnt_q <= '0;
                beat_cnt_q  <= '0;
            end
`ifdef AXI_RD_RESP_WRITE_ERR_EN
            else if (aw_hs) begin
                id_q <= axi_req_i.aw.id;
            end
`endif
            else begin
                if (issue) begin
                    issue_cnt_q <= issue_cnt_q + 9'd1;
                    if (burst_q != BURST_FIXED) begin
                        addr_q <= addr_q + MemAddrWidth'(1);
                    end
                end
                if (r_hs) begin
                    beat_cnt_q <= beat_cnt_q + 8'd1;
                end
            end
        end
    end

    // Next-state and AXI channel outputs for each state.
    always_comb begin
        state_d             = state_q;
        axi_resp_o          = '0;
        axi_resp_o.r.id     = id_q;
        axi_resp_o.r.user   = {AxiUserWidth{1'b0}};
        axi_resp_o.r_valid  = r_valid;
        case (state_q)
            IDLE: begin
                axi_resp_o.ar_ready = 1'b1;
                if (axi_req_i.ar_valid) begin
                    state_d = ar_bad ? ERR : BURST;
                end
`ifdef AXI_RD_RESP_WRITE_ERR_EN
                else if (axi_req_i.aw_valid) begin
                    axi_resp_o.aw_ready = 1'b1;
                    state_d             = WDRAIN;
                end
`endif
            end
            BURST: begin
                axi_resp_o.r.data = fifo_data;
                axi_resp_o.r.resp = RESP_OKAY;
                axi_resp_o.r.last = beat_last;
                if (r_hs && beat_last) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                axi_resp_o.r.resp = RESP_SLVERR;
                axi_resp_o.r.last = beat_last;
                if (r_hs && beat_last) begin
                    state_d = IDLE;
                end
            end
`ifdef AXI_RD_RESP_WRITE_ERR_EN
            WDRAIN: begin
                axi_resp_o.w_ready = 1'b1;
                if (axi_req_i.w_valid && axi_req_i.w.last) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                axi_resp_o.b_valid = 1'b1;
                axi_resp_o.b.id    = id_q;
                axi_resp_o.b.resp  = RESP_SLVERR;
                if (axi_req_i.b_ready) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_rd_line_responder.sv
// Self-checking bench for axi_rd_line_responder: a table of AR bursts with
// hand-decided legality, replayed with r_ready held high, plus hand-written
// sequences for random back-pressure, mid-burst reset and the write path
// (AXI_RD_RESP_WRITE_ERR_EN). Memory word i holds 0x1000 + i.
module tb_axi_rd_line_responder;
    import axi_rd_resp_pkg::*;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  ar_size;
        logic [1:0]  burst;
        logic        exp_err;
    } vec_t;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    axi_req_t       axi_req;
    axi_resp_t      axi_resp;
    logic           mem_req;
    mem_word_addr_t mem_addr;
    logic [63:0]    mem_rdata;

    int             check_count = 0;
    int             error_count = 0;
    int             outstanding = 0;
    mem_word_addr_t req_log[$];
    vec_t           vecs[9];

    axi_rd_line_responder #(
        .mst_req_t  (axi_req_t),
        .mst_resp_t (axi_resp_t)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .axi_req_i   (axi_req),
        .axi_resp_o  (axi_resp),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] memWord(input mem_word_addr_t wa);
        return 64'h1000 + {48'h0, wa};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Synchronous memory: data for a request appears the following cycle.
    always @(posedge clk_i) begin
        if (mem_req) begin
            mem_rdata <= memWord(mem_addr);
        end
    end

    // Logs issued addresses and checks no request goes out with two beats already owed.
    always begin
        @(negedge clk_i);
        #2;
        if (!rst_ni) begin
            outstanding = 0;
        end else begin
            int pop;
            pop = (axi_resp.r_valid && axi_req.r_ready && axi_resp.r.resp == RESP_OKAY) ? 1 : 0;
            if (mem_req) begin
                req_log.push_back(mem_addr);
                checkOutput("credit_at_issue", 64'((outstanding - pop) < 2), 64'd1);
                outstanding++;
            end
            outstanding -= pop;
        end
    end

    // Runs one AR burst and checks every beat, timing, completion and issued addresses.
    task automatic applyStimulus(input vec_t v, input bit rand_ready, input int abort_after);
        int             beats_exp;
        int             beat;
        int             cyc;
        int             first_cyc;
        int             n_req;
        mem_word_addr_t wa;
        mem_word_addr_t exp_wa;
        beats_exp = int'(v.len) + 1;
        beat      = 0;
        cyc       = 0;
        first_cyc = -1;
        wa        = v.addr[18:3];
        req_log.delete();
        @(negedge clk_i);
        #1;
        checkOutput("ar_ready_before_ar", 64'(axi_resp.ar_ready), 64'd1);
        axi_req.ar.id    = v.id;
        axi_req.ar.addr  = v.addr;
        axi_req.ar.len   = v.len;
        axi_req.ar.size  = v.ar_size;
        axi_req.ar.burst = v.burst;
        axi_req.ar_valid = 1'b1;
        @(posedge clk_i);
        #1;
        axi_req.ar_valid = 1'b0;
        while (beat < beats_exp && cyc < 300) begin
            @(negedge clk_i);
            cyc++;
            axi_req.r_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
            #1;
            if (axi_resp.r_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (axi_req.r_ready) begin
                    exp_wa = (v.burst == BURST_FIXED) ? wa : wa + beat[15:0];
                    checkOutput("r_data", axi_resp.r.data, v.exp_err ? 64'h0 : memWord(exp_wa));
                    checkOutput("r_resp", 64'(axi_resp.r.resp), v.exp_err ? 64'(RESP_SLVERR) : 64'(RESP_OKAY));
                    checkOutput("r_id", 64'(axi_resp.r.id), 64'(v.id));
                    checkOutput("r_last", 64'(axi_resp.r.last), 64'(beat == beats_exp - 1));
                    checkOutput("r_user", 64'(axi_resp.r.user), 64'd0);
                    beat++;
                    if (abort_after > 0 && beat == abort_after) begin
                        @(posedge clk_i);
                        #2;
                        checkOutput("r_valid_before_reset", 64'(axi_resp.r_valid), 64'd1);
                        rst_ni = 1'b0;
                        #1;
                        checkOutput("r_valid_in_reset", 64'(axi_resp.r_valid), 64'd0);
                        checkOutput("ar_ready_in_reset", 64'(axi_resp.ar_ready), 64'd1);
                        checkOutput("mem_req_in_reset", 64'(mem_req), 64'd0);
                        @(negedge clk_i);
                        #3;
                        rst_ni          = 1'b1;
                        axi_req.r_ready = 1'b0;
                        return;
                    end
                end
            end
        end
        checkOutput("beats_received", 64'(beat), 64'(beats_exp));
        if (!rand_ready) begin
            // r_valid rises two clocks after the AR edge for good bursts, at once for errors.
            checkOutput("first_valid_cycle", 64'(first_cyc), v.exp_err ? 64'd1 : 64'd3);
            checkOutput("last_beat_cycle", 64'(cyc), 64'(first_cyc + int'(v.len)));
        end
        @(negedge clk_i);
        axi_req.r_ready = 1'b0;
        #1;
        checkOutput("ar_ready_after_last", 64'(axi_resp.ar_ready), 64'd1);
        checkOutput("r_valid_after_last", 64'(axi_resp.r_valid), 64'd0);
        n_req = req_log.size();
        checkOutput("mem_req_count", 64'(n_req), v.exp_err ? 64'd0 : 64'(beats_exp));
        for (int i = 0; i < n_req && i < beats_exp; i++) begin
            exp_wa = (v.burst == BURST_FIXED) ? wa : wa + i[15:0];
            checkOutput("mem_addr", 64'(req_log[i]), 64'(exp_wa));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{id: 4'h3, addr: 64'h40,    len: 8'd7,  ar_size: 3'd3, burst: BURST_INCR,  exp_err: 1'b0};
        vecs[1] = '{id: 4'h1, addr: 64'h18,    len: 8'd0,  ar_size: 3'd3, burst: BURST_INCR,  exp_err: 1'b0};
        vecs[2] = '{id: 4'h5, addr: 64'h40,    len: 8'd15, ar_size: 3'd3, burst: BURST_INCR,  exp_err: 1'b1};
        vecs[3] = '{id: 4'h6, addr: 64'h40,    len: 8'd3,  ar_size: 3'd3, burst: BURST_WRAP,  exp_err: 1'b1};
        vecs[4] = '{id: 4'h2, addr: 64'h20,    len: 8'd3,  ar_size: 3'd3, burst: BURST_FIXED, exp_err: 1'b0};
        vecs[5] = '{id: 4'h7, addr: 64'h7FFF8, len: 8'd1,  ar_size: 3'd3, burst: BURST_INCR,  exp_err: 1'b0};
        vecs[6] = '{id: 4'h4, addr: 64'h100,   len: 8'd1,  ar_size: 3'd2, burst: BURST_INCR,  exp_err: 1'b1};
        vecs[7] = '{id: 4'hA, addr: 64'h45,    len: 8'd2,  ar_size: 3'd3, burst: BURST_INCR,  exp_err: 1'b0};
        vecs[8] = '{id: 4'hC, addr: 64'h80,    len: 8'd8,  ar_size: 3'd3, burst: BURST_INCR,  exp_err: 1'b1};

        axi_req = '0;
        rst_ni  = 1'b1;
        #2;
        rst_ni = 1'b0;
        #2;
        checkOutput("reset_ar_ready", 64'(axi_resp.ar_ready), 64'd1);
        checkOutput("reset_r_valid", 64'(axi_resp.r_valid), 64'd0);
        checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
        checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("reset_aw_ready", 64'(axi_resp.aw_ready), 64'd0);
        checkOutput("reset_w_ready", 64'(axi_resp.w_ready), 64'd0);
        checkOutput("reset_b_valid", 64'(axi_resp.b_valid), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], 1'b0, 0);
        end

        $display("[TB] random r_ready back-pressure");
        applyStimulus(vecs[0], 1'b1, 0);
        applyStimulus(vecs[4], 1'b1, 0);

        $display("[TB] reset after beat 3 of an 8-beat burst");
        applyStimulus(vecs[0], 1'b0, 4);
        applyStimulus(vecs[0], 1'b0, 0);

`ifdef AXI_RD_RESP_WRITE_ERR_EN
        begin
            int whs;
            int cyc;
            $display("[TB] 4-beat write drained with SLVERR");
            @(negedge clk_i);
            axi_req.aw.id    = 4'h9;
            axi_req.aw.len   = 8'd3;
            axi_req.aw_valid = 1'b1;
            #1;
            checkOutput("aw_ready", 64'(axi_resp.aw_ready), 64'd1);
            @(posedge clk_i);
            #1;
            axi_req.aw_valid = 1'b0;
            axi_req.w_valid  = 1'b1;
            whs = 0;
            cyc = 0;
            while (whs < 4 && cyc < 50) begin
                @(negedge clk_i);
                cyc++;
                axi_req.w.data = 64'hDEAD_0000 + 64'(whs);
                axi_req.w.last = (whs == 3);
                #1;
                if (axi_resp.w_ready) whs++;
            end
            @(posedge clk_i);
            #1;
            axi_req.w_valid = 1'b0;
            axi_req.w.last  = 1'b0;
            checkOutput("w_handshakes", 64'(whs), 64'd4);
            @(negedge clk_i);
            #1;
            checkOutput("b_valid", 64'(axi_resp.b_valid), 64'd1);
            checkOutput("b_id", 64'(axi_resp.b.id), 64'h9);
            checkOutput("b_resp", 64'(axi_resp.b.resp), 64'(RESP_SLVERR));
            checkOutput("w_ready_in_wresp", 64'(axi_resp.w_ready), 64'd0);
            axi_req.b_ready = 1'b1;
            @(posedge clk_i);
            #1;
            axi_req.b_ready = 1'b0;
            @(negedge clk_i);
            #1;
            checkOutput("b_valid_after_b", 64'(axi_resp.b_valid), 64'd0);
            checkOutput("ar_ready_after_b", 64'(axi_resp.ar_ready), 64'd1);
            applyStimulus(vecs[1], 1'b0, 0);
        end
`else
        $display("[TB] AW ignored when write support is not built");
        @(negedge clk_i);
        axi_req.aw.id    = 4'h9;
        axi_req.aw_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            checkOutput("aw_ready_tied_off", 64'(axi_resp.aw_ready), 64'd0);
        end
        axi_req.aw_valid = 1'b0;
        applyStimulus(vecs[1], 1'b0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
